// File: rtl/hd44780_rx.sv
`timescale 1ns/1ps
// hd44780_rx: receive side of an HD44780-style parallel bus. Samples the
// asynchronous E/RS/DB lines, assembles bytes in 8-bit or 4-bit mode, models
// the busy flag and tracks the DDRAM address, entry direction and display-on.
//
// Ports:
//   clk         sole clock, all state on rising edge
//   rst         asynchronous active-low reset
//   e           enable strobe (async); a byte/nibble is taken on its falling edge
//   rs          register select, 0 = instruction, 1 = data (async)
//   db[3:0]     data bus DB7..DB4 (async)
//   byte_valid  one-cycle pulse when a byte completes
//   byte_data   last completed byte (held between completions)
//   byte_rs     rs of last completed byte
//   busy        modelled busy flag
//   ddram_addr  DDRAM address counter
//   mode4       1 = 4-bit interface active
//   disp_on     display-on bit from last display-control instruction
//   overrun     sticky: a strobe arrived while busy
module hd44780_rx #(
  parameter int unsigned BUSY_CYCLES  = 10,
  parameter int unsigned CLEAR_CYCLES = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic [3:0] db,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       busy,
  output logic [6:0] ddram_addr,
  output logic       mode4,
  output logic       disp_on,
  output logic       overrun
);

  localparam int unsigned MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {ST_8BIT, ST_4HI, ST_4LO} state_t;

  state_t state, state_nxt;

  logic             e_q1, e_q2, e_q3;
  logic             rs_q1, rs_q2;
  logic [3:0]       db_q1, db_q2;
  logic [3:0]       hi_nib;
  logic             hi_rs;
  logic             inc;
  logic [CNT_W-1:0] cnt;

  logic             strobe_c;
  logic             accept_c;
  logic             done_c;
  logic             hi_load_c;
  logic [7:0]       cdata_c;
  logic             crs_c;
  logic             is_clear_c;
  logic             is_home_c;

  // Two-flop synchronizers; e_q3 is the previous synchronized E for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q1  <= 1'b0;
      e_q2  <= 1'b0;
      e_q3  <= 1'b0;
      rs_q1 <= 1'b0;
      rs_q2 <= 1'b0;
      db_q1 <= 4'h0;
      db_q2 <= 4'h0;
    end else begin
      e_q1  <= e;
      e_q2  <= e_q1;
      e_q3  <= e_q2;
      rs_q1 <= rs;
      rs_q2 <= rs_q1;
      db_q1 <= db;
      db_q2 <= db_q1;
    end
  end

  assign strobe_c = e_q3 & ~e_q2;
  // Strobes seen while busy are dropped entirely, nibbles included
  assign accept_c = strobe_c & ~busy;

  // State register; mode4 follows the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_8BIT;
      mode4 <= 1'b0;
    end else begin
      state <= state_nxt;
      mode4 <= (state_nxt != ST_8BIT);
    end
  end

  // Next-state and byte assembly
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    hi_load_c = 1'b0;
    cdata_c   = {db_q2, 4'h0};
    crs_c     = rs_q2;
    if (accept_c) begin
      case (state)
        ST_8BIT: begin
          done_c = 1'b1;
          if (!rs_q2 && db_q2 == 4'b0010) state_nxt = ST_4HI;
        end
        ST_4HI: begin
          hi_load_c = 1'b1;
          state_nxt = ST_4LO;
        end
        ST_4LO: begin
          done_c    = 1'b1;
          cdata_c   = {hi_nib, db_q2};
          crs_c     = hi_rs;
          state_nxt = (!hi_rs && hi_nib == 4'b0011) ? ST_8BIT : ST_4HI;
        end
        default: state_nxt = ST_8BIT;
      endcase
    end
  end

  assign is_clear_c = !crs_c && (cdata_c == 8'h01);
  assign is_home_c  = !crs_c && (cdata_c[7:1] == 7'b0000001);

  // Byte output, pending high nibble and sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_rs    <= 1'b0;
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      byte_valid <= done_c;
      if (done_c) begin
        byte_data <= cdata_c;
        byte_rs   <= crs_c;
      end
      if (hi_load_c) begin
        hi_nib <= db_q2;
        hi_rs  <= rs_q2;
      end
      if (strobe_c && busy) overrun <= 1'b1;
    end
  end

  // Busy counter loads alongside byte_valid; busy mirrors counter != 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (done_c) begin
      cnt  <= (is_clear_c || is_home_c) ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
      busy <= 1'b1;
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
      busy <= (cnt != CNT_W'(1));
    end
  end

  // Instruction decode and data-write address stepping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ddram_addr <= 7'h00;
      inc        <= 1'b1;
      disp_on    <= 1'b0;
    end else if (done_c) begin
      if (!crs_c) begin
        if (cdata_c[7]) begin
          ddram_addr <= cdata_c[6:0];
        end else if (is_clear_c) begin
          ddram_addr <= 7'h00;
          inc        <= 1'b1;
        end else if (is_home_c) begin
          ddram_addr <= 7'h00;
        end else if (cdata_c[7:2] == 6'b000001) begin
          inc <= cdata_c[1];
        end else if (cdata_c[7:3] == 5'b00001) begin
          disp_on <= cdata_c[2];
        end
      end else begin
        ddram_addr <= inc ? (ddram_addr + 7'd1) : (ddram_addr - 7'd1);
      end
    end
  end

endmodule

// File: doc/hd44780_rx.md
HD44780_RX -- requirements
Module: hd44780_rx

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 10, clk cycles busy after a normal instruction or data write (minimum 1).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 400, clk cycles busy after clear or home (minimum 1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port e  input  1  HD44780 enable strobe, asynchronous to clk.
REQ-006 SHALL have port rs  input  1  register select, 0 = instruction, 1 = data.
REQ-007 SHALL have port db  input  4  data bus (HD44780 DB7..DB4).
REQ-008 SHALL have port byte_valid  output  1  one-cycle pulse when a byte completes.
REQ-009 SHALL have port byte_data  output  8  last completed byte.
REQ-010 SHALL have port byte_rs  output  1  rs of last completed byte.
REQ-011 SHALL have port busy  output  1  modelled busy flag.
REQ-012 SHALL have port ddram_addr  output  7  current DDRAM address counter.
REQ-013 SHALL have port mode4  output  1  1 = 4-bit interface active.
REQ-014 SHALL have port disp_on  output  1  display-on bit (D) from last display control.
REQ-015 SHALL have port overrun  output  1  sticky flag: strobe received while busy.

Function
REQ-016 SHALL pass e, rs and db each through a 2-flop synchronizer; a strobe is a falling edge of synchronized e (1 then 0).
REQ-017 SHALL capture synchronized rs and db in the strobe cycle N; any byte_valid pulse occurs in cycle N+1.
REQ-018 SHALL use states ST_8BIT, ST_4HI and ST_4LO; reset enters ST_8BIT; mode4 = 0 in ST_8BIT and 1 otherwise.
REQ-019 In ST_8BIT, each strobe SHALL complete byte {db,4'h0} with byte_rs = rs; if rs = 0 and db = 4'b0010, the next state SHALL be ST_4HI; otherwise the state stays ST_8BIT.
REQ-020 In ST_4HI, a strobe SHALL store db as the high nibble, store rs, and go to ST_4LO with no byte_valid and no busy.
REQ-021 In ST_4LO, a strobe SHALL complete byte {high nibble, db} with byte_rs equal to the rs stored at the high nibble, then go to ST_4HI.
REQ-022 When a 4-bit byte completes with rs = 0 and data[7:4] = 4'b0011, the next state SHALL be ST_8BIT.
REQ-023 On byte completion with byte_rs = 0, decode in priority order:
- 1xxxxxxx: ddram_addr = data[6:0].
- 00000001 (clear): ddram_addr = 0, inc = 1.
- 0000001x (home): ddram_addr = 0.
- 000001xx (entry mode): inc = data[1].
- 00001xxx (display control): disp_on = data[2].
- all others: no state change.
REQ-024 On byte completion with byte_rs = 1, ddram_addr SHALL step +1 if inc = 1, else -1, modulo 128.
REQ-025 Busy counter SHALL load on the byte_valid cycle: CLEAR_CYCLES for clear or home, BUSY_CYCLES for any other byte; it decrements by 1 each cycle to 0; busy = (counter != 0), so busy is high from the byte_valid cycle for exactly the loaded count.
REQ-026 A strobe while busy = 1 SHALL be ignored (no capture, no state change, no byte_valid) and SHALL set overrun; this applies equally to high nibbles.
REQ-027 overrun SHALL clear only on reset.
REQ-028 byte_data and byte_rs SHALL hold their values between completions.

Reset
REQ-029 rst low SHALL immediately set:
- byte_valid = 0, byte_data = 0, byte_rs = 0.
- busy = 0 (counter 0), ddram_addr = 0, mode4 = 0, disp_on = 0, overrun = 0.
- inc = 1, state ST_8BIT, synchronizers 0.
REQ-030 Reset mid-operation SHALL discard any pending high nibble and cancel any busy period; the next strobe after release is treated as 8-bit.

Verification
REQ-031 After reset, strobe rs=0 db=0x3 -> byte_valid one cycle, byte_data 0x30, mode4 0, busy high exactly 10 cycles.
REQ-032 Strobe db=0x2 in 8-bit -> byte 0x20, mode4 1; then nibbles 0x2, 0x8 -> single byte_valid, byte_data 0x28, mode4 stays 1.
REQ-033 In 4-bit mode, nibbles 0xC, 0x5 (rs=0) -> ddram_addr 0x45; nibbles 0x4, 0x1 (rs=1) -> byte_data 0x41, byte_rs 1, ddram_addr 0x46.
REQ-034 Wrap-around cases:
- ddram_addr 0x7F, data write with inc=1 -> 0x00.
- Entry mode 0x04 (inc=0), then data write at 0x00 -> 0x7F.
REQ-035 Byte 0x01 -> ddram_addr 0, busy 400 cycles; strobe during that window -> overrun 1, no byte_valid, ddram_addr unchanged.
REQ-036 In 4-bit mode, assert rst between high and low nibble -> mode4 0, overrun 0; next strobe db=0x5 -> byte_data 0x50.
